// File: rtl/ila_readout_ctrl.sv
// ila_readout_ctrl: walks the ILA capture ring from the oldest sample into a holding register for the serializer; ILA_READOUT_ABORT_EN adds i_abort/o_aborted
module ila_readout_ctrl #(
  parameter int addr_width = 12,
  parameter int sample_width = 24
) (
  input  logic                    i_clk_ILA,
  input  logic                    i_reset,
  input  logic                    i_start_read,
  input  logic [addr_width-1:0]   i_start_addr,
  output logic [addr_width-1:0]   o_ram_addr,
  output logic                    o_ram_rd_en,
  input  logic [sample_width-1:0] i_ram_data,
  output logic [sample_width-1:0] o_sample,
  output logic                    o_read_active,
  input  logic                    i_next,
  input  logic                    i_tx_empty,
  output logic                    o_busy,
  output logic                    o_done
`ifdef ILA_READOUT_ABORT_EN
  ,input  logic                   i_abort,
  output logic                    o_aborted
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, ACTIVE, DRAIN} state_t;
  localparam logic [addr_width:0] last = {1'b0, {addr_width{1'b1}}};
  state_t state;
  logic [addr_width:0] cnt;
  logic [addr_width-1:0] addr;
  logic abort;
`ifdef ILA_READOUT_ABORT_EN
  assign abort = i_abort && state != IDLE;
  always_ff @(posedge i_clk_ILA)
    o_aborted <= !i_reset && abort;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge i_clk_ILA) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      addr          <= '0;
      o_ram_addr    <= '0;
      o_ram_rd_en   <= 1'b0;
      o_sample      <= '0;
      o_read_active <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      o_ram_rd_en   <= 1'b0;
      o_read_active <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_ram_rd_en <= 1'b0;
      case (state)
        IDLE: if (i_start_read) begin
          addr        <= i_start_addr;
          cnt         <= '0;
          o_ram_addr  <= i_start_addr;
          o_ram_rd_en <= 1'b1;
          o_busy      <= 1'b1;
          state       <= FETCH;
        end
        FETCH: state <= WAIT;
        WAIT: state <= LOAD;
        LOAD: begin
          o_sample      <= i_ram_data;
          addr          <= addr + 1'b1;
          o_read_active <= 1'b1;
          state         <= ACTIVE;
        end
        ACTIVE: if (i_next) begin
          if (cnt == last) state <= DRAIN;
          else begin
            cnt         <= cnt + 1'b1;
            o_ram_addr  <= addr;
            o_ram_rd_en <= 1'b1;
            state       <= FETCH;
          end
        end
        DRAIN: if (i_tx_empty) begin
          o_done        <= 1'b1;
          o_read_active <= 1'b0;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ila_readout_ctrl.sv
// tb_ila_readout_ctrl: randomized readout checks against a ring-order model of the capture buffer
module tb_ila_readout_ctrl;
  localparam int aw = 3;
  localparam int sw = 24;
  localparam int depth = 1 << aw;
  logic clk = 0, rst = 0, start_read = 0, next = 0, tx_empty = 0;
  logic rd_en, ra, busy, done;
  logic [aw-1:0] start_addr = '0, ram_addr;
  logic [sw-1:0] ram_data = '0, sample;
  logic [sw-1:0] mem [depth];
  logic [aw-1:0] rd_q [$];
  int n_vec = 0, n_err = 0, n_done = 0;
`ifdef ILA_READOUT_ABORT_EN
  logic abort = 0, aborted;
`endif
  always #5 clk = ~clk;
  ila_readout_ctrl #(.addr_width(aw), .sample_width(sw)) dut (
    .i_clk_ILA(clk), .i_reset(rst), .i_start_read(start_read), .i_start_addr(start_addr),
    .o_ram_addr(ram_addr), .o_ram_rd_en(rd_en), .i_ram_data(ram_data), .o_sample(sample),
    .o_read_active(ra), .i_next(next), .i_tx_empty(tx_empty), .o_busy(busy), .o_done(done)
`ifdef ILA_READOUT_ABORT_EN
    , .i_abort(abort), .o_aborted(aborted)
`endif
  );
  always @(posedge clk) if (rd_en) ram_data <= mem[ram_addr];
  always @(negedge clk) begin
    if (rd_en) rd_q.push_back(ram_addr);
    if (done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic readout(input logic [aw-1:0] st, input int hold);
    int d0;
    int a;
    d0 = n_done;
    rd_q.delete();
    start_addr = st;
    start_read = 1;
    tick();
    start_read = 0;
    start_addr = ~st;
    chk("busy_fetch", busy, 1);
    chk("rd_en_fetch", rd_en, 1);
    tick();
    tick();
    chk("ra_before_first", ra, 0);
    tick();
    for (int k = 0; k < depth; k++) begin
      a = (int'(st) + k) % depth;
      chk("ra_active", ra, 1);
      chk("sample", sample, mem[a]);
      repeat ($urandom_range(0, 3)) begin
        tick();
        chk("sample_hold", sample, mem[a]);
      end
      if (k == 1) begin
        start_read = 1;
        start_addr = st + 3'd2;
        tick();
        start_read = 0;
        chk("restart_ignored", sample, mem[a]);
      end
      next = 1;
      tick();
      next = 0;
      if (k == depth - 1) break;
      chk("ra_fetch", ra, 1);
      tick();
      if (k == 2) next = 1;
      chk("ra_wait", ra, 1);
      tick();
      next = 0;
      chk("ra_load", ra, 1);
      tick();
    end
    for (int i = 0; i < hold; i++) begin
      chk("ra_drain", ra, 1);
      chk("done_drain", done, 0);
      tick();
    end
    chk("rd_count", rd_q.size(), depth);
    tx_empty = 1;
    tick();
    tx_empty = 0;
    chk("done", done, 1);
    chk("ra_off", ra, 0);
    chk("busy_off", busy, 0);
    tick();
    chk("done_pulse", done, 0);
    for (int k = 0; k < depth; k++) chk("rd_order", rd_q[k], (int'(st) + k) % depth);
    chk("done_count", n_done - d0, 1);
  endtask
  task automatic reset_values(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_addr"}, ram_addr, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_ra"}, ra, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  initial begin
    int d0;
    rst = 1;
    tick();
    tick();
    reset_values("rst_init");
`ifdef ILA_READOUT_ABORT_EN
    chk("rst_init_aborted", aborted, 0);
`endif
    rst = 0;
    tick();
    for (int k = 0; k < depth; k++) mem[k] = sw'(k);
    readout(3'd0, 3);
    readout(3'd6, 20);
    for (int k = 0; k < depth; k++) mem[k] = sw'($urandom);
    readout(3'd7, $urandom_range(0, 5));
    repeat (3) readout(aw'($urandom_range(0, depth - 1)), $urandom_range(0, 6));
    start_addr = 3'd3;
    start_read = 1;
    tick();
    start_read = 0;
    repeat (3) tick();
    next = 1;
    tick();
    next = 0;
    repeat (3) tick();
    chk("pre_reset_ra", ra, 1);
    d0 = n_done;
    tx_empty = 1;
    rst = 1;
    tick();
    tick();
    rst = 0;
    reset_values("rst_mid");
    repeat (3) tick();
    tx_empty = 0;
    chk("rst_no_done", n_done - d0, 0);
    chk("rst_idle_busy", busy, 0);
`ifdef ILA_READOUT_ABORT_EN
    d0 = n_done;
    start_addr = 3'd5;
    start_read = 1;
    tick();
    start_read = 0;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      next = 1;
      tick();
      next = 0;
      if (k < 2) repeat (3) tick();
    end
    abort = 1;
    tick();
    abort = 0;
    chk("abort_flag", aborted, 1);
    chk("abort_ra", ra, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick();
    chk("abort_pulse", aborted, 0);
    chk("abort_no_done", n_done - d0, 0);
    readout(3'd5, 2);
`endif
    readout(aw'($urandom_range(0, depth - 1)), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ila_readout_ctrl.md
# ila_readout_ctrl

Sequences readout of the ILA capture BRAM towards the sample-to-nibble serializer. On a host read command it walks the ring buffer from the oldest captured sample, modulo depth, for exactly `2**addr_width` samples. It prefetches each sample into a holding register and gates the serializer's `read_active`. It sits between the capture BRAM read port and the serializer/SPI-slave output path.

## Interface

**Parameters**
- `addr_width`, 12: BRAM address width. Depth is `2**addr_width` samples.
- `sample_width`, 24: width of one captured sample.

**Ports**
- `i_clk_ILA`, in, 1: ILA clock. All logic runs on its rising edge.
- `i_reset`, in, 1: synchronous, active-high reset.
- `i_start_read`, in, 1: one-cycle pulse that starts readout. Honoured only in IDLE.
- `i_start_addr`, in, `addr_width`: address of the oldest sample. Sampled on `i_start_read`.
- `o_ram_addr`, out, `addr_width`: BRAM read address.
- `o_ram_rd_en`, out, 1: BRAM read enable. Data is valid one cycle after it is asserted.
- `i_ram_data`, in, `sample_width`: BRAM read data.
- `o_sample`, out, `sample_width`: held sample presented to the serializer.
- `o_read_active`, out, 1: serializer enable.
- `i_next`, in, 1: one-cycle pulse from the serializer when it latches `o_sample`.
- `i_tx_empty`, in, 1: high when the serializer/SPI path has shifted out all data.
- `o_busy`, out, 1: high in every state except IDLE.
- `o_done`, out, 1: one-cycle pulse when readout completes.

## Operation

States and transitions:
- **IDLE**: waits for `i_start_read`. On the pulse: `addr <= i_start_addr`, `cnt <= 0`, go to FETCH.
- **FETCH**: `o_ram_rd_en=1`, `o_ram_addr=addr`. Go to WAIT.
- **WAIT**: one cycle for BRAM latency. Go to LOAD.
- **LOAD**: `o_sample <= i_ram_data`, `addr <= addr+1` (wraps modulo `2**addr_width`). Go to ACTIVE.
- **ACTIVE**: `o_read_active=1`. On `i_next`:
  - if `cnt == 2**addr_width - 1`, go to DRAIN;
  - otherwise `cnt <= cnt+1` and go to FETCH.

  `o_sample` holds its value until the next LOAD.
- **DRAIN**: `o_read_active=1`, no further BRAM reads. When `i_tx_empty=1`, pulse `o_done` and go to IDLE.

Rules:
- `o_read_active` stays high continuously from the first entry to ACTIVE until DRAIN exits. FETCH, WAIT and LOAD inside a readout do not drop it.
- `cnt` is `addr_width+1` bits wide. Exactly `2**addr_width` samples are read per command.
- `i_start_read` while `o_busy=1` is ignored.
- `i_next` outside ACTIVE is ignored. The serializer must not request again within 3 cycles.
- `i_start_addr = 2**addr_width - 1`: the read order is that address, then 0, 1, and so on.

## Timing

Reset values (all outputs): `o_ram_addr=0`, `o_ram_rd_en=0`, `o_sample=0`, `o_read_active=0`, `o_busy=0`, `o_done=0`. Internal: state=IDLE, `cnt=0`, `addr=0`.

Reset mid-operation: on the next edge, return to IDLE with the reset values above. No `o_done` is issued.

Latency, counting `i_start_read` high at cycle T:
- T+1: FETCH.
- T+2: WAIT.
- T+3: LOAD.
- T+4: `o_sample` valid and `o_read_active=1`.

Per sample:
- `i_next` high at cycle N means the next `o_sample` is valid at N+4.
- Minimum spacing between `i_next` pulses is 4 cycles.

Completion:
- `o_done` is high in the cycle after DRAIN sees `i_tx_empty=1`.
- `o_read_active` and `o_busy` are 0 in that same cycle.

## Configuration

Macro `ILA_READOUT_ABORT_EN`.

- **Defined**:
  - Adds input `i_abort` (1 bit) and output `o_aborted` (1 bit, reset 0).
  - `i_abort` high in any non-IDLE state forces IDLE on the next edge.
  - In that cycle `o_read_active=0` and `o_aborted=1` for exactly one cycle, and `o_done` is not pulsed.
  - `i_abort` in IDLE has no effect.
  - `i_reset` has priority over `i_abort`.
- **Not defined**: neither port exists. Readout can only be stopped by `i_reset`.

## Test plan

- **Reset**: assert `i_reset` for 2 cycles mid-ACTIVE → all outputs at reset values the next cycle, no `o_done`.
- **Basic readout**: `addr_width=3`, `i_start_addr=0`, BRAM[k]=k, `i_next` every 8 cycles → `o_sample` takes 0..7 in order, `o_read_active` rises at T+4, and 8 `i_next` pulses are consumed. After `i_tx_empty`, one `o_done` pulse follows.
- **Wrap-around**: `i_start_addr=6` with `addr_width=3` → read order 6,7,0,1,2,3,4,5, exactly 8 `o_ram_rd_en` pulses.
- **Ignored inputs**: `i_start_read` re-pulsed during ACTIVE → ignored, sequence unchanged. `i_next` during WAIT → ignored, `cnt` unchanged.
- **Drain hold**: `i_tx_empty` held low for 20 cycles after the last `i_next` → `o_read_active` stays 1 with no BRAM reads. `o_done` follows exactly one cycle after `i_tx_empty` rises.
- **Abort (`ILA_READOUT_ABORT_EN`)**: `i_abort` in FETCH of sample 3 → IDLE next cycle, `o_aborted`=1 for one cycle, `o_done` stays 0, and a new `i_start_read` then restarts from `i_start_addr`.
